// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_seq_pkg: ALU mnemonics, sequencer states and control opcodes shared by the control slice
package alu_ctrl_seq_pkg;

    // ALU operation codes as seen on the ALU OP input
    typedef enum logic [3:0] {
        ADD = 4'h0,
        SUB = 4'h1,
        AND = 4'h2,
        OR  = 4'h3,
        XOR = 4'h4,
        LSH = 4'h5,
        RSH = 4'h6,
        SEQ = 4'h7,
        SNE = 4'h8,
        SLT = 4'h9
    } op_mne;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALTED = 3'd6
    } ctrl_state_t;

    // Non-ALU instruction opcodes; 0x0-0x9 map straight onto op_mne
    localparam logic [3:0] OP_LAST_ALU = 4'h9;
    localparam logic [3:0] OP_LDI      = 4'hA;
    localparam logic [3:0] OP_LW       = 4'hB;
    localparam logic [3:0] OP_SW       = 4'hC;
    localparam logic [3:0] OP_BNZ      = 4'hD;
    localparam logic [3:0] OP_NOP      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

endpackage

// File: rtl/alu_ctrl_seq_pc_unit.sv
// alu_ctrl_seq_pc_unit: program counter with clear, increment and signed 3-bit branch add, all modulo 2^PC_W
module alu_ctrl_seq_pc_unit #(
    parameter int PC_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_inc,
    input  logic            i_br,
    input  logic [2:0]      i_off,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_off;

    assign w_off = {{(PC_W-3){i_off[2]}}, i_off};
    assign o_pc  = r_pc;

    // Clear wins over branch, branch over increment; additions wrap naturally
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)   r_pc <= '0;
        else if (i_clr) r_pc <= '0;
        else if (i_br)  r_pc <= r_pc + w_off;
        else if (i_inc) r_pc <= r_pc + PC_W'(1);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: multi-cycle fetch/decode/exec/mem/wb sequencer driving the ALU, register file and data memory.
// Optional ALU_CTRL_STALL_CNT_EN adds a saturating StallCnt of fetch and memory wait cycles.
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 9,
    parameter int OPS  = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    output logic            IReq,
    output logic [PC_W-1:0] IAddr,
    input  logic            IValid,
    input  logic [IW-1:0]   IData,
    output logic [OPS-1:0]  AluOp,
    output logic            AluImmSel,
    output logic [1:0]      RaddrA,
    output logic [2:0]      RaddrB,
    input  logic            AluZero,
    output logic            RegWe,
    output logic [1:0]      RegWaddr,
    output logic            RegWsel,
    output logic            DReq,
    output logic            DWe,
    input  logic            DReady,
    output logic            Done,
    output logic [PC_W-1:0] PcOut
`ifdef ALU_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     StallCnt
`endif
);

    ctrl_state_t     r_state;
    ctrl_state_t     w_nxt;
    logic [IW-1:0]   r_ir;
    logic [3:0]      w_op;
    logic [1:0]      w_rd;
    logic [2:0]      w_rs;
    logic            w_is_alu, w_is_ldi, w_is_lw, w_is_sw, w_is_bnz, w_is_nop, w_is_halt;
    op_mne           w_alu_op;
    logic            w_start, w_inc, w_br;
    logic [PC_W-1:0] w_pc;

    assign w_op      = r_ir[8:5];
    assign w_rd      = r_ir[4:3];
    assign w_rs      = r_ir[2:0];
    assign w_is_alu  = w_op <= OP_LAST_ALU;
    assign w_is_ldi  = w_op == OP_LDI;
    assign w_is_lw   = w_op == OP_LW;
    assign w_is_sw   = w_op == OP_SW;
    assign w_is_bnz  = w_op == OP_BNZ;
    assign w_is_nop  = w_op == OP_NOP;
    assign w_is_halt = w_op == OP_HALT;

    // Decode is purely a function of the instruction register, so it is stable outside EXEC too.
    // LDI is reg0 | imm3; BNZ compares rd against an immediate zero, so the offset field is masked off B.
    assign w_alu_op  = w_is_alu ? op_mne'(w_op) : w_is_ldi ? OR : w_is_bnz ? SNE : ADD;
    assign AluOp     = OPS'(w_alu_op);
    assign AluImmSel = w_is_ldi | w_is_bnz;
    assign RaddrA    = w_is_ldi ? 2'd0 : w_rd;
    assign RaddrB    = w_is_bnz ? 3'd0 : w_rs;
    assign RegWaddr  = w_rd;

    assign IReq    = r_state == FETCH;
    assign DReq    = r_state == MEM;
    assign DWe     = (r_state == MEM) & w_is_sw;
    assign RegWe   = r_state == WB;
    assign RegWsel = (r_state == WB) & w_is_lw;
    assign Done    = r_state == HALTED;
    assign IAddr   = w_pc;
    assign PcOut   = w_pc;

    assign w_start = Start & (r_state == IDLE || r_state == HALTED);
    assign w_br    = (r_state == EXEC) & w_is_bnz & ~AluZero;
    assign w_inc   = ((r_state == EXEC) & (w_is_bnz | w_is_nop)) |
                     ((r_state == MEM) & DReady & w_is_sw) |
                     (r_state == WB);

    // Next-state selection; handshake inputs only matter in their own state
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = Start ? FETCH : IDLE;
            FETCH:   w_nxt = IValid ? DECODE : FETCH;
            DECODE:  w_nxt = EXEC;
            EXEC:    w_nxt = (w_is_alu | w_is_ldi) ? WB : (w_is_lw | w_is_sw) ? MEM : w_is_halt ? HALTED : FETCH;
            MEM:     w_nxt = !DReady ? MEM : w_is_lw ? WB : FETCH;
            WB:      w_nxt = FETCH;
            HALTED:  w_nxt = Start ? FETCH : HALTED;
            default: w_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_nxt;

    // Instruction register captures the word on the accepted fetch cycle
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)                        r_ir <= '0;
        else if (r_state == FETCH && IValid) r_ir <= IData;

    alu_ctrl_seq_pc_unit #(.PC_W(PC_W)) u_pc (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_start),
        .i_inc   (w_inc),
        .i_br    (w_br),
        .i_off   (w_rs),
        .o_pc    (w_pc)
    );

`ifdef ALU_CTRL_STALL_CNT_EN
    logic [15:0] r_stall;
    logic        w_stall;

    assign w_stall  = (r_state == FETCH && !IValid) || (r_state == MEM && !DReady);
    assign StallCnt = r_stall;

    // Saturating count of wait cycles, restarted whenever a program is started
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)                          r_stall <= '0;
        else if (w_start)                      r_stall <= '0;
        else if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
`endif

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer: the producer side of the ALU's opcode/operand interface.
- Fetches 9-bit instructions over a valid/ready instruction-memory handshake and decodes them into the 4-bit ALU opcode, register-file addresses, immediate select and write enables.
- Sequences data-memory accesses and owns the PC, including branch and halt.
- Sits between instruction memory, register file, ALU and data memory in the CSE141L core.

Parameters:
- PC_W, 8, program counter / instruction address width
- IW, 9, instruction width
- OPS, 4, ALU opcode width (matches op_mne)

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse; leaves IDLE and begins fetch at PC=0
- IReq  out  1  instruction fetch request
- IAddr  out  PC_W  fetch address (=PC)
- IValid  in  1  instruction data valid
- IData  in  IW  instruction word
- AluOp  out  OPS  op_mne code driven to ALU OP
- AluImmSel  out  1  1: ALU InputB = zero-extended imm3
- RaddrA  out  2  register read address A (rd field)
- RaddrB  out  3  register read address B / imm3 (rs field)
- AluZero  in  1  ALU Out==0, sampled in EXEC
- RegWe  out  1  register write strobe, one cycle
- RegWaddr  out  2  register write address
- RegWsel  out  1  0: ALU result, 1: data-memory read data
- DReq  out  1  data-memory request
- DWe  out  1  data-memory write (valid with DReq)
- DReady  in  1  data-memory access complete
- Done  out  1  high in HALTED
- PcOut  out  PC_W  current PC, debug

Behaviour:
- Instruction fields: op=[8:5], rd=[4:3], rs/imm=[2:0].
  - op 0x0-0x9: ALU register ops ADD,SUB,AND,OR,XOR,LSH,RSH,SEQ,SNE,SLT; AluOp=op.
  - op 0xA LDI: rd = imm3, via AluOp=OR, AluImmSel=1, with RaddrA forced to reg0.
  - op 0xB LW: rd = mem[R[rs]].
  - op 0xC SW: mem[R[rs]] = R[rd].
  - op 0xD BNZ: if R[rd]!=0 then PC += sext(imm3), else PC+1. Uses AluOp=SNE with imm 0; taken when AluZero==0.
  - op 0xE: NOP.
  - op 0xF: HALT.
- States:
  - IDLE: leaves on Start, goes to FETCH.
  - FETCH: IReq=1, stays until IValid. Instruction is latched on the IValid cycle, then DECODE.
  - DECODE: 1 cycle. Drives RaddrA/RaddrB, then EXEC.
  - EXEC: 1 cycle. AluOp/AluImmSel are valid here.
    - ALU op or LDI: go to WB.
    - LW/SW: go to MEM.
    - BNZ/NOP: go to FETCH, with PC updated at the end of EXEC.
    - HALT: go to HALTED.
  - MEM: DReq=1 (DWe=1 for SW) held until the DReady cycle.
    - LW: then WB.
    - SW: then FETCH with PC+1.
  - WB: RegWe=1 for exactly one cycle, RegWaddr=rd, RegWsel=1 only for LW. PC+1, then FETCH.
  - HALTED: Done=1. Stays until Start, which sets PC=0 and goes to FETCH.
- Latency:
  - ALU op: 4 cycles + fetch wait.
  - LW: 5 + fetch wait + memory wait.
- PC arithmetic is modulo 2^PC_W; 0xFF+1 wraps to 0x00, and a branch offset below 0 wraps.
- IValid outside FETCH and DReady outside MEM are ignored.
- Start outside IDLE/HALTED is ignored.
- Reset (asynchronous, any state) → IDLE:
  - PC=0, instruction register=0.
  - IReq, DReq, DWe, RegWe, Done, AluImmSel, RegWsel = 0.
  - AluOp=ADD(0), address outputs 0.
- When not in EXEC, AluOp holds the decoded value. It is "don't care" for the ALU, but must be deterministic.

Optional Feature:
- Macro: ALU_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output StallCnt[15:0], counting cycles in FETCH with !IValid plus cycles in MEM with !DReady.
  - Saturates at 0xFFFF.
  - Cleared by reset and by Start.
- When undefined: no port and no counter logic.

Decomposition:
- Package definitions gains:
  - ctrl_state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED).
  - Opcode constants OP_LDI=4'hA, OP_LW=4'hB, OP_SW=4'hC, OP_BNZ=4'hD, OP_NOP=4'hE, OP_HALT=4'hF.
  - Reuses the existing op_mne enum.
- One sub-module, pc_unit: PC register with increment, signed branch add, reset-to-zero and wrap.

Test Plan:
- Reset mid-MEM (DReq=1) → same-cycle DReq=0, state IDLE, PC=0; Start → IAddr=0 with IReq=1.
- Fetch 9'b0001_01_010 (SUB r1,r2), IValid delayed 3 cycles → IReq held 3 extra cycles; AluOp=1 in EXEC; one RegWe pulse with RegWaddr=1, RegWsel=0; next IAddr=1.
- LW r2,(r3) with DReady after 2 cycles → DReq=1/DWe=0 for 3 cycles, then RegWe with RegWsel=1, RegWaddr=2; SW → DWe=1, no RegWe.
- BNZ at PC=5 with imm=3'b110 (-2): AluZero=0 → next IAddr=3; AluZero=1 → next IAddr=6.
- Reaching PC=0xFF with NOP → next IAddr=0x00.
- HALT → Done=1 stays high with IValid toggling; Start → Done=0, IAddr=0; with ALU_CTRL_STALL_CNT_EN, the StallCnt total from the previous scenarios matches the injected wait cycles.
